// File: rtl/ota_bitstream_decimator.sv
// ota_bitstream_decimator
// Resynchronises the comparator bit, integrates it over 2^DEC_LOG2 enabled
// cycles and hands off a ones-density sample plus a transition count through
// a single-entry valid/ready holding register with a sticky overrun flag.
module ota_bitstream_decimator #(
  parameter int DEC_LOG2 = 7
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                cmp_in,
  output logic [DEC_LOG2:0]   out_sample,
  output logic [DEC_LOG2:0]   out_toggles,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                overrun,
  output logic                busy
);
  localparam int SW = DEC_LOG2 + 1;
  localparam logic [DEC_LOG2-1:0] WIN_ONE  = DEC_LOG2'(1);
  localparam logic [DEC_LOG2-1:0] WIN_LAST = '1;

  logic                s1, s2, prev;
  logic                cmp_s, tog_s;
  logic [DEC_LOG2-1:0] win_cnt;
  logic [SW-1:0]       ones_acc, tog_acc;
  logic [SW-1:0]       ones_nxt, tog_nxt;
  logic                win_end;

  assign cmp_s    = s2;
  assign tog_s    = cmp_s ^ prev;
  assign ones_nxt = ones_acc + SW'(cmp_s);
  assign tog_nxt  = tog_acc + SW'(tog_s);
  assign win_end  = en && (win_cnt == WIN_LAST);
  assign busy     = (win_cnt != '0);

  // Two-flop synchroniser plus previous-bit register; free-running.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      prev <= 1'b0;
    end else begin
      s1   <= cmp_in;
      s2   <= s1;
      prev <= cmp_s;
    end
  end

  // Window integrator; dropping en discards the partial window.
  always_ff @(posedge clk) begin
    if (rst || !en || win_end) begin
      win_cnt  <= '0;
      ones_acc <= '0;
      tog_acc  <= '0;
    end else begin
      win_cnt  <= win_cnt + WIN_ONE;
      ones_acc <= ones_nxt;
      tog_acc  <= tog_nxt;
    end
  end

  // Holding register: newest result wins, overrun is sticky until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_sample  <= '0;
      out_toggles <= '0;
      out_valid   <= 1'b0;
      overrun     <= 1'b0;
    end else if (win_end) begin
      out_sample  <= ones_nxt;
      out_toggles <= tog_nxt;
      out_valid   <= 1'b1;
      if (out_valid && !out_ready) overrun <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_ota_bitstream_decimator.sv
// tb_ota_bitstream_decimator
// Directed test-plan scenarios plus randomized traffic, checked against a
// history-based behavioural model of the decimator.
module tb_ota_bitstream_decimator;
  localparam int DL = 3;
  localparam int W  = 1 << DL;

  logic clk = 1'b0;
  logic rst = 1'b1, en = 1'b0, cmp_in = 1'b0, out_ready = 1'b0;
  logic [DL:0] out_sample, out_toggles;
  logic out_valid, overrun, busy;

  int checks = 0;
  int errors = 0;

  // model state
  int hist[$];
  int n, ones, togs, m_samp, m_tog;
  bit m_valid, m_ovr;

  ota_bitstream_decimator #(.DEC_LOG2(DL)) dut (
    .clk(clk), .rst(rst), .en(en), .cmp_in(cmp_in),
    .out_sample(out_sample), .out_toggles(out_toggles),
    .out_valid(out_valid), .out_ready(out_ready),
    .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Model: cmp_s at an edge is the raw input sampled two edges earlier,
  // prev the one three edges earlier; reset zeroes that history.
  task automatic model_edge();
    int cs, pv;
    bit wend;
    if (rst) begin
      hist = '{0, 0, 0};
      n = 0; ones = 0; togs = 0;
      m_samp = 0; m_tog = 0; m_valid = 0; m_ovr = 0;
      return;
    end
    cs = hist[1];
    pv = hist[2];
    hist.push_front(int'(cmp_in));
    void'(hist.pop_back());
    wend = 0;
    if (en) begin
      ones += cs;
      togs += (cs != pv) ? 1 : 0;
      n++;
      wend = (n == W);
    end
    if (wend) begin
      if (m_valid && !out_ready) m_ovr = 1;
      m_valid = 1;
      m_samp = ones;
      m_tog = togs;
    end else if (m_valid && out_ready) begin
      m_valid = 0;
    end
    if (!en || wend) begin
      n = 0; ones = 0; togs = 0;
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    chk("valid", 32'(out_valid), 32'(m_valid));
    chk("overrun", 32'(overrun), 32'(m_ovr));
    chk("busy", 32'(busy), 32'(n != 0));
    chk("sample", 32'(out_sample), 32'(m_samp));
    chk("toggles", 32'(out_toggles), 32'(m_tog));
  endtask

  task automatic run(input int k);
    for (int i = 0; i < k; i++) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    run(2);
    chk("rst_sample", 32'(out_sample), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_overrun", 32'(overrun), 0);
    chk("rst_busy", 32'(busy), 0);
    rst = 1'b0;
  endtask

  initial begin
    hist = '{0, 0, 0};
    // constant 1, always ready
    cmp_in = 1'b1; en = 1'b1; out_ready = 1'b1;
    do_reset();
    run(W);
    chk("s1_first_valid", 32'(out_valid), 1);
    chk("s1_first_sample", 32'(out_sample), 6);
    chk("s1_first_tog", 32'(out_toggles), 1);
    run(1);
    chk("s1_pulse", 32'(out_valid), 0);
    run(W - 1);
    chk("s1_second_sample", 32'(out_sample), 8);
    chk("s1_second_tog", 32'(out_toggles), 0);
    chk("s1_second_valid", 32'(out_valid), 1);

    // toggling input
    do_reset();
    for (int i = 0; i < 3 * W; i++) begin
      cmp_in = ~cmp_in;
      step();
      if (i == 2 * W - 1 || i == 3 * W - 1) begin
        chk("tog_sample", 32'(out_sample), 4);
        chk("tog_toggles", 32'(out_toggles), 8);
      end
    end

    // consumer stalled
    cmp_in = 1'b1; out_ready = 1'b0;
    do_reset();
    run(W);
    chk("ovr_first_valid", 32'(out_valid), 1);
    chk("ovr_first_ovr", 32'(overrun), 0);
    run(W);
    chk("ovr_second_ovr", 32'(overrun), 1);
    chk("ovr_second_sample", 32'(out_sample), 8);
    out_ready = 1'b1;
    run(1);
    out_ready = 1'b0;
    chk("ovr_drain_valid", 32'(out_valid), 0);
    chk("ovr_sticky", 32'(overrun), 1);

    // en dropped at window cycle 5
    out_ready = 1'b1;
    do_reset();
    run(2 * W + 5);
    en = 1'b0;
    run(1);
    en = 1'b1;
    run(W - 1);
    chk("en_drop_no_result", 32'(out_valid), 0);
    run(1);
    chk("en_drop_valid", 32'(out_valid), 1);
    chk("en_drop_sample", 32'(out_sample), 8);

    // ready only on the window-end cycle while valid
    out_ready = 1'b0;
    do_reset();
    run(W);
    run(W - 1);
    out_ready = 1'b1;
    run(1);
    out_ready = 1'b0;
    chk("rdy_end_valid", 32'(out_valid), 1);
    chk("rdy_end_ovr", 32'(overrun), 0);
    chk("rdy_end_sample", 32'(out_sample), 8);

    // reset mid-window
    out_ready = 1'b1;
    do_reset();
    run(W + 4);
    rst = 1'b1;
    run(1);
    chk("mid_rst_sample", 32'(out_sample), 0);
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    rst = 1'b0;
    run(W - 1);
    chk("mid_rst_early", 32'(out_valid), 0);
    run(1);
    chk("mid_rst_valid2", 32'(out_valid), 1);
    chk("mid_rst_sample2", 32'(out_sample), 6);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cmp_in    = 1'($urandom_range(0, 1));
      en        = ($urandom_range(0, 15) != 0);
      out_ready = 1'($urandom_range(0, 1));
      rst       = ($urandom_range(0, 199) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
